pharmacy_desk_ctrl: RTL
=======================

Name: pharmacy_desk_ctrl

Overview:
- Command initiator that drives the pharmacy queue memory's mode/ID/time interface, so user logic never sequences the memory directly.
- Accepts check-in, serve and list requests over a valid/ready handshake.
- Issues correctly timed memory commands, keeps a shadow occupancy count, and turns the memory's list stream into clean per-ID valid strobes with a completion pulse.

Parameters:
- CAPACITY, 10, maximum queue entries; must match the memory's capacity.
- LIST_TIMEOUT, 32, maximum cycles in list states before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  00 list, 10 check-in, 11 serve; 01 is ignored (accepted, no action).
- req_id  in  5  student ID for check-in; 0 is illegal and is rejected.
- req_time  in  8  check-in time.
- mem_mode  out  2  mode to memory; 01 = idle (memory takes no action).
- mem_id  out  5  studentID to memory.
- mem_time  out  8  checkInTime to memory.
- mem_list_out  in  5  memory listOutput.
- mem_list_busy  in  1  memory listBusy.
- mem_ready  in  1  memory ready.
- list_valid  out  1  list_id is a valid listed ID this cycle.
- list_id  out  5  listed student ID.
- list_done  out  1  one-cycle pulse: list finished.
- list_count  out  4  IDs delivered in the last list; held until the next list starts.
- list_err  out  1  set with list_done if the list timed out.
- reject  out  1  one-cycle pulse: request refused.
- occupancy  out  4  shadow entry count, 0..CAPACITY.

Behaviour:
- Reset (sync, rst=1 at posedge) values:
  - State IDLE; mem_mode=01; mem_id=0; mem_time=0.
  - occupancy=0; list_count=0; list_valid=0; list_id=0.
  - list_done=0; list_err=0; reject=0; req_ready=0 during reset cycle.
- Reset mid-operation aborts any command; mem_mode returns to 01 the next cycle.
- All outputs are registered.
- States: IDLE, CHKIN, SERVE, LIST_WAIT, LIST_RUN, DONE.
- IDLE:
  - req_ready=1; a request is accepted on req_valid&req_ready.
  - op 10: if occupancy==CAPACITY or req_id==0, pulse reject next cycle and stay IDLE. Otherwise latch id/time and go to CHKIN.
  - op 11: if occupancy==0, pulse reject and stay IDLE. Otherwise go to SERVE.
  - op 00: if occupancy==0, pulse list_done with list_count=0 next cycle and go to DONE without issuing a command. Otherwise clear list_count and go to LIST_WAIT.
  - op 01: no action.
- CHKIN:
  - mem_mode=10 with mem_id/mem_time valid for exactly one cycle.
  - occupancy+1; then DONE.
- SERVE:
  - mem_mode=11 for exactly one cycle.
  - occupancy-1; then DONE.
- LIST_WAIT:
  - mem_mode=00 held.
  - Wait for the first cycle with mem_list_busy=1 (the restart cycle, which carries no ID), then go to LIST_RUN.
- LIST_RUN:
  - mem_mode=00 held.
  - Each cycle with mem_list_busy=1: register list_id=mem_list_out, pulse list_valid, list_count+1. Saturate at 15.
  - First cycle with mem_list_busy=0 and mem_ready=1: pulse list_done, drop to mem_mode=01, go to DONE.
- Timeout:
  - A cycle counter runs from entry to LIST_WAIT.
  - When it reaches LIST_TIMEOUT: pulse list_done with list_err=1, mem_mode=01, go to DONE.
  - list_err is cleared at the next list start.
- DONE:
  - One cycle, mem_mode=01, req_ready=0.
  - Guarantees an idle cycle between memory commands; then IDLE.
- Throughput: check-in and serve take 3 cycles from acceptance to the next req_ready.
- Occupancy never wraps; arithmetic is 4-bit unsigned, bounded by the reject checks.

Decomposition:
- Shared package pharmacy_pkg holds:
  - mode constants MODE_LIST=00, MODE_IDLE=01, MODE_CHKIN=10, MODE_SERVE=11.
  - The state enum.
  - CAPACITY default.
  - ID width 5 and time width 8.
- One sub-module is natural: pharmacy_list_capture. It implements the LIST_WAIT/LIST_RUN stream capture, count and timeout, and is reusable by other readers of the memory.

Test Plan:
- Reset, then check-in id 5 at t=20 -> mem_mode=10, mem_id=5, mem_time=20 for one cycle; occupancy=1; req_ready low for 3 cycles.
- Eleven check-ins against a memory model -> first ten issue mode 10; the eleventh pulses reject with no mode 10; occupancy=10.
- Serve with occupancy 0 -> reject pulse, mem_mode stays 01. Check-in with req_id=0 -> reject.
- Check-ins (7,t=30),(3,t=10),(9,t=20), then list -> list_valid on three cycles in heap order 3,7,9; list_done with list_count=3, list_err=0.
- List with empty queue -> list_done next cycle, list_count=0, mem_mode never 00.
- List with mem_list_busy stuck 0 and mem_ready stuck 0 -> list_done with list_err=1 after 32 cycles. Assert rst mid-LIST_RUN -> mem_mode=01 and occupancy=0 the next cycle.

Source files
------------

// File: rtl/pharmacy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pharmacy_pkg
// Description : Shared types and constants for the pharmacy queue desk
//               controller and its list-capture helper. Holds the memory mode
//               encodings, request opcodes, the controller state encoding,
//               the default queue capacity and the ID / time field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package pharmacy_pkg;

    localparam int CAPACITY_DEFAULT = 10;
    localparam int ID_W             = 5;
    localparam int TIME_W           = 8;

    // Memory mode encodings
    localparam logic [1:0] MODE_LIST  = 2'b00;
    localparam logic [1:0] MODE_IDLE  = 2'b01;
    localparam logic [1:0] MODE_CHKIN = 2'b10;
    localparam logic [1:0] MODE_SERVE = 2'b11;

    // Request opcodes mirror the memory modes; 01 is a no-op request
    localparam logic [1:0] OP_LIST  = 2'b00;
    localparam logic [1:0] OP_NOP   = 2'b01;
    localparam logic [1:0] OP_CHKIN = 2'b10;
    localparam logic [1:0] OP_SERVE = 2'b11;

    // Controller state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_CHKIN     = 3'd1;
    localparam state_t ST_SERVE     = 3'd2;
    localparam state_t ST_LIST_WAIT = 3'd3;
    localparam state_t ST_LIST_RUN  = 3'd4;
    localparam state_t ST_DONE      = 3'd5;

endpackage : pharmacy_pkg
`default_nettype wire

// File: rtl/pharmacy_list_capture.sv
`default_nettype none
// ============================================================================
// Module      : pharmacy_list_capture
// Description : Turns the queue memory's list stream into per-ID valid
//               strobes. Skips the restart cycle, counts delivered IDs
//               (saturating at 15), detects completion and aborts on timeout.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_start           - a list request was accepted this cycle
//               i_empty           - that list request found the queue empty
//               i_wait / i_run    - controller is in LIST_WAIT / LIST_RUN
//               i_list_out        - memory listOutput
//               i_list_busy       - memory listBusy
//               i_mem_ready       - memory ready
//               o_go_run          - restart cycle seen, move to LIST_RUN
//               o_finish          - list ends this cycle (normal or timeout)
//               o_list_valid/id   - registered listed-ID strobe and value
//               o_list_count      - IDs delivered in the current/last list
//               o_list_done       - registered completion pulse
//               o_list_err        - list ended by timeout
// Revision    : 1.0 - initial release
// ============================================================================
module pharmacy_list_capture
    import pharmacy_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_empty,
    input  logic            i_wait,
    input  logic            i_run,
    input  logic [ID_W-1:0] i_list_out,
    input  logic            i_list_busy,
    input  logic            i_mem_ready,
    output logic            o_go_run,
    output logic            o_finish,
    output logic            o_list_valid,
    output logic [ID_W-1:0] o_list_id,
    output logic [3:0]      o_list_count,
    output logic            o_list_done,
    output logic            o_list_err
);

    localparam int                 c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_list_valid;
    logic [ID_W-1:0]    r_list_id;
    logic [3:0]         r_list_count;
    logic               r_list_done;
    logic               r_list_err;

    logic w_active;
    logic w_timeout;
    logic w_normal_done;
    logic w_capture;

    // r_cnt is zero on the first list cycle, so the last allowed cycle is
    // TIMEOUT-1 and the list states occupy exactly TIMEOUT cycles.
    assign w_active      = i_wait | i_run;
    assign w_timeout     = w_active && (r_cnt == c_last);
    assign w_normal_done = i_run && !i_list_busy && i_mem_ready;
    // Only LIST_RUN busy cycles carry IDs; the restart cycle is seen in WAIT.
    assign w_capture     = i_run && i_list_busy && !w_timeout;

    assign o_go_run = i_wait && i_list_busy && !w_timeout;
    assign o_finish = w_normal_done || w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_list_valid <= 1'b0;
            r_list_id    <= '0;
            r_list_count <= 4'd0;
            r_list_done  <= 1'b0;
            r_list_err   <= 1'b0;
        end else begin
            r_list_valid <= w_capture;
            r_list_done  <= w_normal_done || w_timeout || (i_start && i_empty);

            if (w_capture) begin
                r_list_id <= i_list_out;
            end

            if (i_start) begin
                r_cnt        <= '0;
                r_list_count <= 4'd0;
                r_list_err   <= 1'b0;
            end else begin
                if (w_active && (r_cnt != c_last)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_capture && (r_list_count != 4'hF)) begin
                    r_list_count <= r_list_count + 4'd1;
                end
                // A clean finish in the same cycle as the deadline wins.
                if (w_timeout && !w_normal_done) begin
                    r_list_err <= 1'b1;
                end
            end
        end
    end

    assign o_list_valid = r_list_valid;
    assign o_list_id    = r_list_id;
    assign o_list_count = r_list_count;
    assign o_list_done  = r_list_done;
    assign o_list_err   = r_list_err;

endmodule : pharmacy_list_capture
`default_nettype wire

// File: rtl/pharmacy_desk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pharmacy_desk_ctrl
// Description : Command initiator for the pharmacy queue memory. Accepts
//               check-in / serve / list requests over valid/ready, issues
//               one-cycle memory commands separated by an idle cycle, keeps a
//               shadow occupancy count and delivers the list stream as clean
//               per-ID strobes with a completion pulse.
// Ports       : clk, rst                     - clock, sync active-high reset
//               req_valid/ready/op/id/time   - request handshake
//               mem_mode/id/time             - command outputs to memory
//               mem_list_out/busy, mem_ready - memory status inputs
//               list_valid/id/done/count/err - list results
//               reject                       - request refused pulse
//               occupancy                    - shadow entry count
// Revision    : 1.0 - initial release
// ============================================================================
module pharmacy_desk_ctrl
    import pharmacy_pkg::*;
#(
    parameter int CAPACITY     = CAPACITY_DEFAULT,
    parameter int LIST_TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ID_W-1:0]   req_id,
    input  logic [TIME_W-1:0] req_time,
    output logic [1:0]        mem_mode,
    output logic [ID_W-1:0]   mem_id,
    output logic [TIME_W-1:0] mem_time,
    input  logic [ID_W-1:0]   mem_list_out,
    input  logic              mem_list_busy,
    input  logic              mem_ready,
    output logic              list_valid,
    output logic [ID_W-1:0]   list_id,
    output logic              list_done,
    output logic [3:0]        list_count,
    output logic              list_err,
    output logic              reject,
    output logic [3:0]        occupancy
);

    localparam logic [3:0] c_cap = 4'(CAPACITY);

    state_t            r_state;
    logic              r_req_ready;
    logic [1:0]        r_mem_mode;
    logic [ID_W-1:0]   r_mem_id;
    logic [TIME_W-1:0] r_mem_time;
    logic [3:0]        r_occupancy;
    logic              r_reject;

    state_t     w_next_state;
    logic [1:0] w_next_mode;
    logic       w_accept;
    logic       w_reject;
    logic       w_list_start;
    logic       w_list_empty;
    logic       w_cap_go_run;
    logic       w_cap_finish;

    assign w_accept = req_valid && r_req_ready && (r_state == ST_IDLE);

    always_comb begin
        w_next_state = r_state;
        w_reject     = 1'b0;
        w_list_start = 1'b0;
        w_list_empty = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (req_op)
                        OP_CHKIN: begin
                            if ((r_occupancy == c_cap) || (req_id == '0)) begin
                                w_reject = 1'b1;
                            end else begin
                                w_next_state = ST_CHKIN;
                            end
                        end
                        OP_SERVE: begin
                            if (r_occupancy == 4'd0) begin
                                w_reject = 1'b1;
                            end else begin
                                w_next_state = ST_SERVE;
                            end
                        end
                        OP_LIST: begin
                            w_list_start = 1'b1;
                            if (r_occupancy == 4'd0) begin
                                // Nothing to list: report an empty list without
                                // touching the memory.
                                w_list_empty = 1'b1;
                                w_next_state = ST_DONE;
                            end else begin
                                w_next_state = ST_LIST_WAIT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_CHKIN:     w_next_state = ST_DONE;
            ST_SERVE:     w_next_state = ST_DONE;
            ST_LIST_WAIT: begin
                if (w_cap_finish) begin
                    w_next_state = ST_DONE;
                end else if (w_cap_go_run) begin
                    w_next_state = ST_LIST_RUN;
                end
            end
            ST_LIST_RUN: begin
                if (w_cap_finish) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:      w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // The mode register follows the state being entered, so each command
    // lasts exactly as long as its state and DONE forces an idle cycle.
    always_comb begin
        w_next_mode = MODE_IDLE;
        case (w_next_state)
            ST_CHKIN:     w_next_mode = MODE_CHKIN;
            ST_SERVE:     w_next_mode = MODE_SERVE;
            ST_LIST_WAIT: w_next_mode = MODE_LIST;
            ST_LIST_RUN:  w_next_mode = MODE_LIST;
            default:      w_next_mode = MODE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_mem_mode  <= MODE_IDLE;
            r_mem_id    <= '0;
            r_mem_time  <= '0;
            r_occupancy <= 4'd0;
            r_reject    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_mem_mode <= w_next_mode;
            r_reject   <= w_reject;
            // Ready rises only after a full IDLE cycle: the first IDLE cycle
            // after DONE (or reset) keeps it low, giving the 3-cycle turnaround.
            r_req_ready <= (w_next_state == ST_IDLE) && (r_state == ST_IDLE);

            if (w_next_state == ST_CHKIN) begin
                r_mem_id   <= req_id;
                r_mem_time <= req_time;
            end

            if (r_state == ST_CHKIN) begin
                r_occupancy <= r_occupancy + 4'd1;
            end else if (r_state == ST_SERVE) begin
                r_occupancy <= r_occupancy - 4'd1;
            end
        end
    end

    pharmacy_list_capture #(
        .TIMEOUT (LIST_TIMEOUT)
    ) u_list_capture (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_list_start),
        .i_empty      (w_list_empty),
        .i_wait       (r_state == ST_LIST_WAIT),
        .i_run        (r_state == ST_LIST_RUN),
        .i_list_out   (mem_list_out),
        .i_list_busy  (mem_list_busy),
        .i_mem_ready  (mem_ready),
        .o_go_run     (w_cap_go_run),
        .o_finish     (w_cap_finish),
        .o_list_valid (list_valid),
        .o_list_id    (list_id),
        .o_list_count (list_count),
        .o_list_done  (list_done),
        .o_list_err   (list_err)
    );

    assign req_ready = r_req_ready;
    assign mem_mode  = r_mem_mode;
    assign mem_id    = r_mem_id;
    assign mem_time  = r_mem_time;
    assign reject    = r_reject;
    assign occupancy = r_occupancy;

endmodule : pharmacy_desk_ctrl
`default_nettype wire
